// File: rtl/traffic_light_ctrl_param.sv
// ----------------------------------------------------------------------------
// traffic_light_ctrl_param
//
// Highway / side-road intersection controller with cycle-count phase timing.
// It sits between the road-sensor pad and the lamp driver.
//
// The highway rests on green. A side-road vehicle is served only after the
// highway minimum green has elapsed. Each side-road green is bounded below by
// SIDE_MIN_GREEN and above by SIDE_MAX_GREEN. Every change between greens
// passes through yellow and then an all-red clearance. flash_en drives the
// intersection into a blinking night/fault mode, and it too always goes
// through yellow and all-red first.
//
// Ports:
//   clk        in   system clock, rising edge
//   clr_n      in   asynchronous active-low reset
//   sensor     in   side-road vehicle present (asynchronous, synchronised here)
//   flash_en   in   flash-mode request (synchronous to clk)
//   highway    out  highway lamp code: 0 RED, 1 YELLOW, 2 GREEN, 3 OFF
//   small_road out  side-road lamp code, same encoding
//   state_o    out  current FSM state (debug/status)
//
// Interface note: there is no valid/ready handshake here. The outputs are
// level signals that are registered and valid on every cycle. They change
// only on a rising clk edge, or immediately when clr_n asserts.
// ----------------------------------------------------------------------------
module traffic_light_ctrl_param #(
    parameter int TW             = 8,
    parameter int HWY_MIN_GREEN  = 8,
    parameter int YELLOW_T       = 3,
    parameter int ALLRED_T       = 2,
    parameter int SIDE_MIN_GREEN = 4,
    parameter int SIDE_MAX_GREEN = 10,
    parameter int FLASH_HALF     = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       sensor,
    input  logic       flash_en,
    output logic [1:0] highway,
    output logic [1:0] small_road,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        HWY_GREEN   = 3'd0,
        HWY_YELLOW  = 3'd1,
        ALL_RED1    = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED2    = 3'd5,
        FLASH       = 3'd6
    } state_t;

    localparam logic [1:0] L_RED    = 2'd0;
    localparam logic [1:0] L_YELLOW = 2'd1;
    localparam logic [1:0] L_GREEN  = 2'd2;
    localparam logic [1:0] L_OFF    = 2'd3;

    // Exit thresholds: a duration D ends when the timer reads D-1.
    localparam logic [TW-1:0] HMG_LAST  = TW'(HWY_MIN_GREEN - 1);
    localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] SMIN_LAST = TW'(SIDE_MIN_GREEN - 1);
    localparam logic [TW-1:0] SMAX_LAST = TW'(SIDE_MAX_GREEN - 1);
    localparam logic [TW-1:0] FH_LAST   = TW'(FLASH_HALF - 1);
    localparam logic [TW-1:0] CNT_MAX   = '1;

    state_t          state, state_n;
    logic [TW-1:0]   cnt, cnt_n;
    logic            phase, phase_n;
    logic [1:0]      hw_n, sr_n;
    logic            sens_m, sens_s;

    // Next-state decision.
    always_comb begin
        state_n = state;
        case (state)
            HWY_GREEN:
                if (flash_en || (cnt >= HMG_LAST && sens_s)) state_n = HWY_YELLOW;
            HWY_YELLOW:
                if (cnt == YEL_LAST) state_n = ALL_RED1;
            ALL_RED1:
                if (cnt == AR_LAST) state_n = flash_en ? FLASH : SIDE_GREEN;
            SIDE_GREEN:
                // Max green ends the phase even while a vehicle is still present.
                if (flash_en || cnt == SMAX_LAST || (cnt >= SMIN_LAST && !sens_s))
                    state_n = SIDE_YELLOW;
            SIDE_YELLOW:
                if (cnt == YEL_LAST) state_n = ALL_RED2;
            ALL_RED2:
                if (cnt == AR_LAST) state_n = flash_en ? FLASH : HWY_GREEN;
            FLASH:
                if (!flash_en) state_n = ALL_RED2;
            default:
                state_n = ALL_RED2;
        endcase
    end

    // Phase timer and blink phase.
    // In FLASH the timer wraps at FLASH_HALF-1, so that it always equals
    // cnt mod FLASH_HALF. The phase toggles on every wrap. This keeps the
    // blink running forever instead of stalling once the timer saturates.
    always_comb begin
        cnt_n   = cnt;
        phase_n = 1'b0;
        if (state_n != state) begin
            cnt_n   = '0;
            phase_n = 1'b0;
        end else if (state == FLASH) begin
            if (cnt == FH_LAST) begin
                cnt_n   = '0;
                phase_n = ~phase;
            end else begin
                cnt_n   = cnt + TW'(1);
                phase_n = phase;
            end
        end else if (cnt != CNT_MAX) begin
            cnt_n = cnt + TW'(1);
        end
    end

    // Lamp codes are decoded from the next state, so that the registered
    // lamps change on the same edge as the state register.
    always_comb begin
        hw_n = L_RED;
        sr_n = L_RED;
        case (state_n)
            HWY_GREEN:   hw_n = L_GREEN;
            HWY_YELLOW:  hw_n = L_YELLOW;
            SIDE_GREEN:  sr_n = L_GREEN;
            SIDE_YELLOW: sr_n = L_YELLOW;
            FLASH: begin
                hw_n = phase_n ? L_OFF : L_YELLOW;
                sr_n = phase_n ? L_OFF : L_RED;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sens_m     <= 1'b0;
            sens_s     <= 1'b0;
            state      <= ALL_RED2;
            cnt        <= '0;
            phase      <= 1'b0;
            highway    <= L_RED;
            small_road <= L_RED;
        end else begin
            sens_m     <= sensor;
            sens_s     <= sens_m;
            state      <= state_n;
            cnt        <= cnt_n;
            phase      <= phase_n;
            highway    <= hw_n;
            small_road <= sr_n;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// ----------------------------------------------------------------------------
// tb_traffic_light_ctrl_param
//
// Directed bench for traffic_light_ctrl_param using the default parameters.
// The driver issues inputs just after each falling edge. For every falling
// edge it pushes the hand-computed {state_o, highway, small_road} word that
// the DUT must show at that edge. The monitor pops one entry per falling edge
// (or on async_ev, for the mid-cycle reset check) and compares it.
// ----------------------------------------------------------------------------
module tb_traffic_light_ctrl_param;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       sensor;
    logic       flash_en;
    logic [1:0] highway;
    logic [1:0] small_road;
    logic [2:0] state_o;

    traffic_light_ctrl_param dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .sensor     (sensor),
        .flash_en   (flash_en),
        .highway    (highway),
        .small_road (small_road),
        .state_o    (state_o)
    );

    // Clock: rising edges at 5, 15, 25, ...; falling edges at 10, 20, ...
    always #5 clk = ~clk;

    // Expected words: {state[2:0], highway[1:0], small_road[1:0]}.
    localparam logic [6:0] V_G      = {3'd0, 2'd2, 2'd0};
    localparam logic [6:0] V_Y      = {3'd1, 2'd1, 2'd0};
    localparam logic [6:0] V_AR1    = {3'd2, 2'd0, 2'd0};
    localparam logic [6:0] V_SG     = {3'd3, 2'd0, 2'd2};
    localparam logic [6:0] V_SY     = {3'd4, 2'd0, 2'd1};
    localparam logic [6:0] V_AR2    = {3'd5, 2'd0, 2'd0};
    localparam logic [6:0] V_FL_ON  = {3'd6, 2'd1, 2'd0};
    localparam logic [6:0] V_FL_OFF = {3'd6, 2'd3, 2'd3};

    logic [6:0] exp_q[$];
    string      tag_q[$];
    int         total = 0;
    int         bad   = 0;
    event       async_ev;

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [6:0] e;
        logic [6:0] act;
        string      t;
        forever begin
            @(negedge clk or async_ev);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                act = {state_o, highway, small_road};
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s @%0t: got st=%0d hw=%0d sr=%0d, want st=%0d hw=%0d sr=%0d",
                             t, $time, act[6:4], act[3:2], act[1:0], e[6:4], e[3:2], e[1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Push n expectations, one per upcoming falling edge.
    task automatic expect_n(input logic [6:0] v, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v);
            tag_q.push_back(tag);
            @(negedge clk);
        end
    endtask

    // Assert reset for one sample, then release.
    // The all-red seen at the release sample and at the next edge is the clearance.
    task automatic rst_pulse(input logic sens_v);
        clr_n  = 1'b0;
        sensor = sens_v;
        expect_n(V_AR2, 1, "reset_state");
        clr_n = 1'b1;
        expect_n(V_AR2, 1, "reset_clear");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr_n    = 1'b1;
        sensor   = 1'b0;
        flash_en = 1'b0;
        #1;

        // 1: no traffic -> highway rests on green.
        rst_pulse(1'b0);
        expect_n(V_G, 100, "idle_hwy_green");

        // 2: sensor held from reset -> full cycle, side green cut at max.
        rst_pulse(1'b1);
        expect_n(V_G,   8,  "t2_hwy_green");
        expect_n(V_Y,   3,  "t2_hwy_yellow");
        expect_n(V_AR1, 2,  "t2_allred1");
        expect_n(V_SG,  10, "t2_side_max");
        expect_n(V_SY,  3,  "t2_side_yellow");
        expect_n(V_AR2, 2,  "t2_allred2");
        expect_n(V_G,   8,  "t2_hwy_green2");
        expect_n(V_Y,   1,  "t2_hwy_yellow2");

        // 3: a 3-cycle sensor pulse raised while the timer reads 6.
        //    The synchroniser delays it, so yellow follows the cnt=8 cycle.
        //    The side road then gets only its minimum green.
        rst_pulse(1'b0);
        expect_n(V_G, 7, "t3_green_pre");
        sensor = 1'b1;
        expect_n(V_G, 2, "t3_green_sync");
        expect_n(V_Y, 1, "t3_yellow_a");
        sensor = 1'b0;
        expect_n(V_Y,   2, "t3_yellow_b");
        expect_n(V_AR1, 2, "t3_allred1");
        expect_n(V_SG,  4, "t3_side_min");
        expect_n(V_SY,  3, "t3_side_yellow");
        expect_n(V_AR2, 2, "t3_allred2");
        expect_n(V_G,   5, "t3_hwy_rest");

        // 4: flash requested on the second side-green cycle.
        rst_pulse(1'b1);
        expect_n(V_G,   8, "t4_hwy_green");
        expect_n(V_Y,   3, "t4_hwy_yellow");
        expect_n(V_AR1, 2, "t4_allred1");
        expect_n(V_SG,  2, "t4_side_green");
        flash_en = 1'b1;
        expect_n(V_SY,  3, "t4_side_yellow");
        expect_n(V_AR2, 2, "t4_allred2");
        for (int k = 0; k < 2; k++) begin
            expect_n(V_FL_ON,  4, "t4_flash_on");
            expect_n(V_FL_OFF, 4, "t4_flash_off");
        end

        // 5: leave flash -> full clearance, then highway green.
        flash_en = 1'b0;
        sensor   = 1'b0;
        expect_n(V_AR2, 2, "t5_allred2");
        expect_n(V_G,   6, "t5_hwy_green");

        // Flash and sensor together during min green: flash wins,
        // but it still goes through yellow and all-red.
        flash_en = 1'b1;
        sensor   = 1'b1;
        expect_n(V_Y,     3, "fs_yellow");
        expect_n(V_AR1,   2, "fs_allred1");
        expect_n(V_FL_ON, 2, "fs_flash");
        flash_en = 1'b0;
        expect_n(V_AR2, 2, "fs_allred2");
        expect_n(V_G,   8, "fs_hwy_green");
        expect_n(V_Y,   3, "fs_hwy_yellow");
        expect_n(V_AR1, 2, "fs_allred1b");
        expect_n(V_SG,  3, "fs_side_green");

        // 6: asynchronous reset mid side green, between clock edges.
        #2 clr_n = 1'b0;
        #1;
        exp_q.push_back(V_AR2);
        tag_q.push_back("async_reset");
        -> async_ev;
        expect_n(V_AR2, 1, "async_reset_hold");
        clr_n = 1'b1;
        expect_n(V_AR2, 1, "post_reset_allred");
        expect_n(V_G,   4, "post_reset_green");

        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
